bnn_frame_loader: RTL



---
 rtl/bnn_uart_pkg.sv | 20 ++
 rtl/uart_byte_timer.sv | 37 +++
 rtl/bnn_frame_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bnn_uart_pkg.sv
// Shared types and constants for the BNN UART input path.
package bnn_uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  localparam byte_t DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte-lane index width; a single-byte payload still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter. Loaded with TIMEOUT_CYCLES-1 on every accepted
// byte and counted down once per cycle while running; expire marks the cycle
// in which the TIMEOUT_CYCLES-th consecutive idle cycle is in progress, so a
// byte arriving in that same cycle can still win. Saturates at zero.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // Down-counter: load has priority over clear, clear over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  // Terminal-count compare; only meaningful while the owner is running it.
  assign expire = (count == '0);

endmodule

// File: rtl/bnn_frame_loader.sv
// Sync-hunting frame assembler between the UART receiver and the BNN core.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | hunting for the sync byte, everything else silently dropped
//   ST_LOAD  | collecting payload bytes into the assembly register
//   ST_CHECK | waiting for the XOR checksum byte
//   ST_HOLD  | checked frame presented on frame_data until the core takes it
module bnn_frame_loader
  import bnn_uart_pkg::*;
#(
  parameter int    PAYLOAD_BYTES  = 8,
  parameter byte_t SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int    TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_err,
  output logic [PAYLOAD_BYTES*8-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       busy,
  output logic                       csum_err,
  output logic                       abort_err,
  output logic                       ovf_err
);

  localparam int FW    = PAYLOAD_BYTES * 8;
  localparam int IDX_W = idx_width(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  byte_t            csum;
  logic [FW-1:0]    asm_q;

  logic in_frame;
  logic sync_hit;
  logic byte_take;
  logic tmr_load;
  logic tmr_clear;
  logic tmr_expire;

  // Timer control: reload on the sync byte and on every accepted frame byte;
  // outside LOAD/CHECK it is held at zero.
  always_comb begin
    in_frame  = (state == ST_LOAD) || (state == ST_CHECK);
    sync_hit  = (state == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    byte_take = in_frame && rx_valid && !rx_err;
    tmr_load  = sync_hit || byte_take;
    tmr_clear = !in_frame;
  end

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .clear  (tmr_clear),
    .run    (in_frame),
    .expire (tmr_expire)
  );

  // Frame FSM with assembly register, running checksum and registered outputs.
  // rx_err beats a coincident byte; a coincident byte beats timer expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      csum        <= '0;
      asm_q       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      csum_err    <= 1'b0;
      abort_err   <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      csum_err  <= 1'b0;
      abort_err <= 1'b0;
      ovf_err   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (sync_hit) begin
            idx   <= '0;
            csum  <= '0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (rx_err) begin
            abort_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
              if (idx == IDX_W'(i)) asm_q[i*8 +: 8] <= rx_data;
            end
            csum <= csum ^ rx_data;
            if (idx == LAST_IDX) begin
              state <= ST_CHECK;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (tmr_expire) begin
            abort_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_CHECK: begin
          if (rx_err) begin
            abort_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            if (rx_data == csum) begin
              frame_data  <= asm_q;
              frame_valid <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              csum_err <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end
          end else if (tmr_expire) begin
            abort_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (rx_valid) ovf_err <= 1'b1;
          if (frame_ready) begin
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          frame_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
